// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared widths, watermarks and FSM state type for the data-memory port arbiter.
package dmem_port_arbiter_pkg;
    localparam int WORD_SIZE_P = 16;
    localparam int SB_ENTRY    = 8;
    localparam int SB_CNT_W    = $clog2(SB_ENTRY) + 1;
    localparam int STARVE_MAX  = 4;
    localparam int STARVE_W    = $clog2(STARVE_MAX + 1);

    localparam logic [SB_CNT_W-1:0] SB_HI_WM     = SB_CNT_W'(6);
    localparam logic [SB_CNT_W-1:0] SB_LO_WM     = SB_CNT_W'(2);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    typedef enum logic {LD_PRI, ST_PRI} mem_arb_state_e;
endpackage

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between LSU loads and store-buffer drains.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   mispredict_i,
    input  logic                   ld_v_i,
    input  logic [WORD_SIZE_P-1:0] ld_addr_i,
    output logic                   ld_ready_o,
    output logic                   ld_data_v_o,
    output logic [WORD_SIZE_P-1:0] ld_data_o,
    input  logic                   st_v_i,
    input  logic [WORD_SIZE_P-1:0] st_addr_i,
    input  logic [WORD_SIZE_P-1:0] st_data_i,
    output logic                   st_ready_o,
    input  logic [SB_CNT_W-1:0]    sb_count_i,
    output logic                   mem_w_v_o,
    output logic [WORD_SIZE_P-1:0] mem_w_addr_o,
    output logic [WORD_SIZE_P-1:0] mem_w_data_o,
    output logic                   mem_r_v_o,
    output logic [WORD_SIZE_P-1:0] mem_r_addr_o,
    input  logic [WORD_SIZE_P-1:0] mem_r_data_i
);
    mem_arb_state_e        r_state;
    logic [STARVE_W-1:0]   r_starve_cnt;
    logic                  r_rd_pend;
    logic                  w_ld_grant;
    logic                  w_st_grant;
    logic [STARVE_W-1:0]   w_starve_nxt;

    assign w_ld_grant = ~reset_i & ld_v_i & ~mispredict_i & (r_state == LD_PRI | ~st_v_i);
    assign w_st_grant = ~reset_i & st_v_i & ~w_ld_grant;

    assign w_starve_nxt = (st_v_i & ~w_st_grant)
                        ? ((r_starve_cnt == STARVE_LIMIT) ? r_starve_cnt : r_starve_cnt + 1'b1)
                        : '0;

    assign ld_ready_o   = w_ld_grant;
    assign st_ready_o   = w_st_grant;
    assign mem_r_v_o    = w_ld_grant;
    assign mem_r_addr_o = w_ld_grant ? ld_addr_i : '0;
    assign mem_w_v_o    = w_st_grant;
    assign mem_w_addr_o = w_st_grant ? st_addr_i : '0;
    assign mem_w_data_o = w_st_grant ? st_data_i : '0;
    assign ld_data_v_o  = r_rd_pend & ~mispredict_i;
    assign ld_data_o    = ld_data_v_o ? mem_r_data_i : '0;

    // Starvation is judged on the updated count so the forced switch lands on the next conflict cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= LD_PRI;
            r_starve_cnt <= '0;
            r_rd_pend    <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_rd_pend    <= w_ld_grant;
            r_state      <= (r_state == LD_PRI)
                          ? ((sb_count_i >= SB_HI_WM || w_starve_nxt == STARVE_LIMIT) ? ST_PRI : LD_PRI)
                          : ((sb_count_i <= SB_LO_WM && w_starve_nxt == '0) ? LD_PRI : ST_PRI);
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: vector table, directed sequences and random traffic with a load-data scoreboard.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    logic                   clk_i = 1'b0;
    logic                   reset_i = 1'b1;
    logic                   mispredict_i = 1'b0;
    logic                   ld_v_i = 1'b0;
    logic [WORD_SIZE_P-1:0] ld_addr_i = '0;
    logic                   ld_ready_o;
    logic                   ld_data_v_o;
    logic [WORD_SIZE_P-1:0] ld_data_o;
    logic                   st_v_i = 1'b0;
    logic [WORD_SIZE_P-1:0] st_addr_i = '0;
    logic [WORD_SIZE_P-1:0] st_data_i = '0;
    logic                   st_ready_o;
    logic [SB_CNT_W-1:0]    sb_count_i = '0;
    logic                   mem_w_v_o;
    logic [WORD_SIZE_P-1:0] mem_w_addr_o;
    logic [WORD_SIZE_P-1:0] mem_w_data_o;
    logic                   mem_r_v_o;
    logic [WORD_SIZE_P-1:0] mem_r_addr_o;
    logic [WORD_SIZE_P-1:0] mem_r_data_i = '0;

    dmem_port_arbiter dut (
        .clk_i(clk_i), .reset_i(reset_i), .mispredict_i(mispredict_i),
        .ld_v_i(ld_v_i), .ld_addr_i(ld_addr_i), .ld_ready_o(ld_ready_o),
        .ld_data_v_o(ld_data_v_o), .ld_data_o(ld_data_o),
        .st_v_i(st_v_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_ready_o(st_ready_o),
        .sb_count_i(sb_count_i),
        .mem_w_v_o(mem_w_v_o), .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o),
        .mem_r_v_o(mem_r_v_o), .mem_r_addr_o(mem_r_addr_o), .mem_r_data_i(mem_r_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic                ld;
        logic                st;
        logic                mp;
        logic [SB_CNT_W-1:0] cnt;
        logic                eld;
        logic                est;
    } vec_t;

    int                     total = 0;
    int                     bad = 0;
    logic [WORD_SIZE_P-1:0] sbq[$];
    logic                   prev_rv = 1'b0;
    logic [WORD_SIZE_P-1:0] prev_ra = '0;

    function automatic logic [WORD_SIZE_P-1:0] mem_val(input logic [WORD_SIZE_P-1:0] a);
        return a ^ 16'hBEFF;
    endfunction

    task automatic chk(input string nm, input logic [WORD_SIZE_P-1:0] act, input logic [WORD_SIZE_P-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_ldrdy"}, ld_ready_o, 0);
        chk({nm, "_strdy"}, st_ready_o, 0);
        chk({nm, "_ldv"}, ld_data_v_o, 0);
        chk({nm, "_ldd"}, ld_data_o, 0);
        chk({nm, "_wv"}, mem_w_v_o, 0);
        chk({nm, "_rv"}, mem_r_v_o, 0);
        chk({nm, "_wa"}, mem_w_addr_o, 0);
        chk({nm, "_wd"}, mem_w_data_o, 0);
        chk({nm, "_ra"}, mem_r_addr_o, 0);
    endtask

    // Asserts reset asynchronously with live requests, holds it two edges, then releases.
    task automatic do_reset(input string nm);
        ld_v_i = 1'b1; st_v_i = 1'b1; mispredict_i = 1'b0;
        ld_addr_i = 16'h1234; st_addr_i = 16'h5678; st_data_i = 16'h9ABC; sb_count_i = 4'd8;
        mem_r_data_i = 16'hFFFF;
        reset_i = 1'b1;
        #1 chk_zero_outputs(nm);
        repeat (2) @(posedge clk_i);
        #1 chk_zero_outputs({nm, "_held"});
        reset_i = 1'b0;
        ld_v_i = 1'b0; st_v_i = 1'b0; sb_count_i = '0;
        sbq.delete();
        prev_rv = 1'b0;
    endtask

    task automatic cyc(input logic ld, input logic [WORD_SIZE_P-1:0] la, input logic st,
                       input logic [WORD_SIZE_P-1:0] sa, input logic [WORD_SIZE_P-1:0] sd,
                       input logic [SB_CNT_W-1:0] cnt, input logic mp);
        logic [WORD_SIZE_P-1:0] exp;
        @(posedge clk_i);
        #1;
        mem_r_data_i = prev_rv ? mem_val(prev_ra) : 16'h5A5A;
        ld_v_i = ld; ld_addr_i = la; st_v_i = st; st_addr_i = sa; st_data_i = sd;
        sb_count_i = cnt; mispredict_i = mp;
        #2;
        if (sbq.size() > 0) begin
            exp = sbq.pop_front();
            chk("ld_data_v", ld_data_v_o, {15'd0, ~mp});
            chk("ld_data", ld_data_o, mp ? 16'h0 : exp);
        end else begin
            chk("ld_data_v_idle", ld_data_v_o, 0);
        end
        chk("rw_exclusive", mem_w_v_o & mem_r_v_o, 0);
        chk("r_v_mirror", mem_r_v_o, ld_ready_o);
        chk("w_v_mirror", mem_w_v_o, st_ready_o);
        if (ld_ready_o) begin
            chk("r_addr", mem_r_addr_o, la);
            sbq.push_back(mem_val(la));
        end
        if (st_ready_o) begin
            chk("w_addr", mem_w_addr_o, sa);
            chk("w_data", mem_w_data_o, sd);
        end
        prev_rv = mem_r_v_o;
        prev_ra = mem_r_addr_o;
    endtask

    task automatic gr(input string nm, input logic eld, input logic est);
        chk({nm, "_ld_ready"}, ld_ready_o, {15'd0, eld});
        chk({nm, "_st_ready"}, st_ready_o, {15'd0, est});
    endtask

    initial begin
        vec_t tbl[9];
        int   den;
        logic ld, st, mp;
        logic [SB_CNT_W-1:0] cnt;
        logic [WORD_SIZE_P-1:0] la, sa, sd;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0};

        do_reset("reset");

        // 1: first load after reset, data one cycle later
        cyc(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0, 4'd0, 1'b0);
        gr("t1_issue", 1'b1, 1'b0);
        chk("t1_mem_r_v", mem_r_v_o, 1);
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 4'd0, 1'b0);
        chk("t1_beef", ld_data_o, 16'hBEEF);

        do_reset("reset_tbl");
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].ld, 16'h0100 + 16'(i), tbl[i].st, 16'h0200 + 16'(i), 16'hC000 + 16'(i),
                tbl[i].cnt, tbl[i].mp);
            gr($sformatf("tbl%0d", i), tbl[i].eld, tbl[i].est);
        end

        // 2: starvation forces store priority on the fifth conflict cycle
        do_reset("reset_t2");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 16'h0300 + 16'(i), 1'b1, 16'h0400, 16'hAAAA, 4'd3, 1'b0);
            gr($sformatf("t2_c%0d", i + 1), 1'b1, 1'b0);
        end
        cyc(1'b1, 16'h0310, 1'b1, 16'h0400, 16'hAAAA, 4'd3, 1'b0);
        gr("t2_c5", 1'b0, 1'b1);

        // 3: high watermark, hysteresis between marks, low watermark exit, full SB
        do_reset("reset_t3");
        cyc(1'b1, 16'h0500, 1'b1, 16'h0600, 16'h1111, 4'd6, 1'b0);
        gr("t3_hi_first", 1'b1, 1'b0);
        cyc(1'b1, 16'h0501, 1'b1, 16'h0601, 16'h2222, 4'd6, 1'b0);
        gr("t3_st_pri", 1'b0, 1'b1);
        cyc(1'b1, 16'h0502, 1'b1, 16'h0602, 16'h3333, 4'd4, 1'b0);
        gr("t3_mid_hold", 1'b0, 1'b1);
        cyc(1'b1, 16'h0503, 1'b1, 16'h0603, 16'h4444, 4'd2, 1'b0);
        gr("t3_lo_edge", 1'b0, 1'b1);
        cyc(1'b1, 16'h0504, 1'b1, 16'h0604, 16'h5555, 4'd2, 1'b0);
        gr("t3_back_ld", 1'b1, 1'b0);
        cyc(1'b1, 16'h0505, 1'b1, 16'h0605, 16'h6666, 4'd4, 1'b0);
        gr("t3_mid_ld", 1'b1, 1'b0);
        cyc(1'b1, 16'h0506, 1'b1, 16'h0606, 16'h7777, 4'd8, 1'b0);
        gr("t3_full_first", 1'b1, 1'b0);
        cyc(1'b1, 16'h0507, 1'b1, 16'h0607, 16'h8888, 4'd8, 1'b0);
        gr("t3_full_st", 1'b0, 1'b1);

        // 4: mispredict in the response cycle and in the issue cycle
        do_reset("reset_t4");
        cyc(1'b1, 16'h0040, 1'b0, 16'h0, 16'h0, 4'd0, 1'b0);
        gr("t4_issue", 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 4'd0, 1'b1);
        chk("t4_killed", ld_data_v_o, 0);
        cyc(1'b1, 16'h0041, 1'b0, 16'h0, 16'h0, 4'd0, 1'b1);
        gr("t4_same_cycle", 1'b0, 1'b0);
        chk("t4_no_read", mem_r_v_o, 0);
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 4'd0, 1'b0);
        chk("t4_no_resp", ld_data_v_o, 0);

        // 6: async reset while a response is pending
        do_reset("reset_t6");
        cyc(1'b1, 16'h0020, 1'b0, 16'h0, 16'h0, 4'd0, 1'b0);
        @(posedge clk_i);
        #1;
        mem_r_data_i = mem_val(16'h0020);
        ld_v_i = 1'b0;
        #1 chk("t6_pending", ld_data_v_o, 1);
        do_reset("t6_async");

        // 5: random traffic
        den = 0;
        for (int i = 0; i < 3000; i++) begin
            ld = 1'($urandom);
            st = 1'($urandom);
            mp = ($urandom_range(0, 7) == 0);
            cnt = SB_CNT_W'($urandom_range(0, SB_ENTRY));
            la = 16'($urandom);
            sa = 16'($urandom);
            sd = 16'($urandom);
            cyc(ld, la, st, sa, sd, cnt, mp);
            chk("rnd_ld_req", ld_ready_o & ~(ld & ~mp), 0);
            chk("rnd_st_req", st_ready_o & ~st, 0);
            chk("rnd_work", ld_ready_o | st_ready_o, (ld & ~mp) | st);
            den = (st && !st_ready_o) ? den + 1 : 0;
            chk("rnd_starve", (den > STARVE_MAX) ? 16'd1 : 16'd0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
